// File: rtl/unsaved_timer_sched.sv
// unsaved_timer_sched: round-robin scheduler that lends one hardware timer to
// NUM_REQ requesters. For the granted requester it programs the period and
// starts a one-shot, waits for the interrupt (or an abort), then clears the
// timeout status and pulses done.
module unsaved_timer_sched #(
   parameter int NUM_REQ = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [32*NUM_REQ-1:0]  period,
   input  logic                   abort,
   output logic [NUM_REQ-1:0]     grant,
   output logic [NUM_REQ-1:0]     done,
   output logic                   aborted,
   output logic                   busy,
   output logic [2:0]             tmr_address,
   output logic                   tmr_chipselect,
   output logic                   tmr_write_n,
   output logic [15:0]            tmr_writedata,
   input  logic                   tmr_irq
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WR_PL    = 3'd1,
      WR_PH    = 3'd2,
      WR_CTRL  = 3'd3,
      WAIT_IRQ = 3'd4,
      STOP     = 3'd5,
      CLR      = 3'd6,
      DONE     = 3'd7
   } state_t;

   state_t               state_q, state_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic [31:0]          period_q, period_d;
   logic [IDX_W-1:0]     start_q, start_d;     // first index searched next time
   logic                 abort_flag_q, abort_flag_d;

   logic                 pick_valid;
   logic [IDX_W-1:0]     pick_idx;
   logic [NUM_REQ-1:0]   pick_onehot;
   logic [31:0]          pick_period;
   logic [IDX_W-1:0]     pick_next;

   // Round-robin search over req starting at start_q, wrapping at NUM_REQ.
   always_comb begin
      int cand;
      cand        = 0;
      pick_valid  = 1'b0;
      pick_idx    = '0;
      pick_onehot = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = int'(start_q) + k;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         if (!pick_valid && req[cand]) begin
            pick_valid = 1'b1;
            pick_idx   = cand[IDX_W-1:0];
         end
      end
      if (pick_valid) begin
         pick_onehot[pick_idx] = 1'b1;
      end
      pick_period = period[32*int'(pick_idx) +: 32];
      if (int'(pick_idx) == NUM_REQ - 1) begin
         pick_next = '0;
      end else begin
         pick_next = pick_idx + 1'b1;
      end
   end

   // State register: all flops, synchronous reset abandons any transaction.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         period_q     <= '0;
         start_q      <= '0;
         abort_flag_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         period_q     <= period_d;
         start_q      <= start_d;
         abort_flag_q <= abort_flag_d;
      end
   end

   // Next-state logic; req is only looked at in IDLE, abort only in WAIT_IRQ.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      period_d     = period_q;
      start_d      = start_q;
      abort_flag_d = abort_flag_q;
      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               grant_d      = pick_onehot;
               period_d     = pick_period;
               start_d      = pick_next;
               abort_flag_d = 1'b0;
               state_d      = WR_PL;
            end
         end
         WR_PL:   state_d = WR_PH;
         WR_PH:   state_d = WR_CTRL;
         WR_CTRL: state_d = WAIT_IRQ;
         WAIT_IRQ: begin
            // A simultaneous irq wins: the timeout really did expire.
            if (tmr_irq) begin
               state_d = CLR;
            end else if (abort) begin
               abort_flag_d = 1'b1;
               state_d      = STOP;
            end
         end
         STOP:    state_d = CLR;
         CLR:     state_d = DONE;
         DONE: begin
            grant_d = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs decoded from the current state; each write state lasts one cycle.
   always_comb begin
      grant          = grant_q;
      done           = '0;
      aborted        = 1'b0;
      busy           = (state_q != IDLE);
      tmr_address    = 3'd0;
      tmr_chipselect = 1'b0;
      tmr_write_n    = 1'b1;
      tmr_writedata  = 16'h0000;
      case (state_q)
         WR_PL: begin
            tmr_chipselect = 1'b1;
            tmr_write_n    = 1'b0;
            tmr_address    = 3'd2;
            tmr_writedata  = period_q[15:0];
         end
         WR_PH: begin
            tmr_chipselect = 1'b1;
            tmr_write_n    = 1'b0;
            tmr_address    = 3'd3;
            tmr_writedata  = period_q[31:16];
         end
         WR_CTRL: begin
            tmr_chipselect = 1'b1;
            tmr_write_n    = 1'b0;
            tmr_address    = 3'd1;
            tmr_writedata  = 16'h0005;
         end
         STOP: begin
            tmr_chipselect = 1'b1;
            tmr_write_n    = 1'b0;
            tmr_address    = 3'd1;
            tmr_writedata  = 16'h0008;
         end
         CLR: begin
            tmr_chipselect = 1'b1;
            tmr_write_n    = 1'b0;
            tmr_address    = 3'd0;
            tmr_writedata  = 16'h0000;
         end
         DONE: begin
            done    = grant_q;
            aborted = abort_flag_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_unsaved_timer_sched.sv
// Directed bench for unsaved_timer_sched: walks complete services (irq,
// abort, irq+abort, dropped req), round-robin order and mid-operation reset.
module tb_unsaved_timer_sched;

   localparam int N = 4;

   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   req;
   logic [32*N-1:0] period;
   logic           abort;
   logic [N-1:0]   grant;
   logic [N-1:0]   done;
   logic           aborted;
   logic           busy;
   logic [2:0]     tmr_address;
   logic           tmr_chipselect;
   logic           tmr_write_n;
   logic [15:0]    tmr_writedata;
   logic           tmr_irq;

   int n_cmp = 0;
   int n_bad = 0;

   logic [18:0] wr_log[$];    // {address, data} of each bus write
   logic [4:0]  done_log[$];  // {aborted, done} of each done pulse

   always #5 clk = ~clk;

   unsaved_timer_sched #(.NUM_REQ(N)) dut (
      .clk            (clk),
      .reset          (reset),
      .req            (req),
      .period         (period),
      .abort          (abort),
      .grant          (grant),
      .done           (done),
      .aborted        (aborted),
      .busy           (busy),
      .tmr_address    (tmr_address),
      .tmr_chipselect (tmr_chipselect),
      .tmr_write_n    (tmr_write_n),
      .tmr_writedata  (tmr_writedata),
      .tmr_irq        (tmr_irq)
   );

   // Log bus writes and done pulses mid-cycle.
   always @(negedge clk) begin
      if (tmr_chipselect && !tmr_write_n) wr_log.push_back({tmr_address, tmr_writedata});
      if (done != '0 || aborted) done_log.push_back({aborted, done});
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // mode: 0 = irq completion (abort pulsed outside WAIT_IRQ), 1 = abort,
   // 2 = irq and abort in the same cycle. Entered and left in IDLE.
   task automatic service(input string tag, input logic [N-1:0] req_v,
                          input logic [N-1:0] exp_g, input int mode, input bit drop);
      logic [18:0] exp_w[$];
      logic [31:0] p;
      int idx;
      idx = 0;
      for (int i = 0; i < N; i++) if (exp_g[i]) idx = i;
      p = period[32*idx +: 32];
      exp_w.push_back({3'd2, p[15:0]});
      exp_w.push_back({3'd3, p[31:16]});
      exp_w.push_back({3'd1, 16'h0005});
      if (mode == 1) exp_w.push_back({3'd1, 16'h0008});
      exp_w.push_back({3'd0, 16'h0000});

      check_val({tag, "_idle_busy"}, 32'(busy), 32'd0);
      wr_log.delete();
      done_log.delete();
      req = req_v;
      step();                                  // WR_PL
      check_val({tag, "_grant"}, 32'(grant), 32'(exp_g));
      check_val({tag, "_busy"}, 32'(busy), 32'd1);
      if (drop) req = '0;
      if (mode == 0) abort = 1'b1;
      step();                                  // WR_PH
      step();                                  // WR_CTRL
      abort = 1'b0;
      step();                                  // WAIT_IRQ
      check_val({tag, "_wait_cs"}, 32'(tmr_chipselect), 32'd0);
      check_val({tag, "_wait_wrn"}, 32'(tmr_write_n), 32'd1);
      step();                                  // still WAIT_IRQ
      if (mode != 1) tmr_irq = 1'b1;
      if (mode != 0) abort = 1'b1;
      step();                                  // CLR or STOP
      tmr_irq = 1'b0;
      abort   = 1'b0;
      if (mode == 1) step();                   // CLR
      step();                                  // DONE
      check_val({tag, "_done"}, 32'(done), 32'(exp_g));
      check_val({tag, "_aborted"}, 32'(aborted), (mode == 1) ? 32'd1 : 32'd0);
      step();                                  // IDLE
      check_val({tag, "_done_clr"}, 32'(done), 32'd0);
      check_val({tag, "_busy_clr"}, 32'(busy), 32'd0);
      check_val({tag, "_grant_clr"}, 32'(grant), 32'd0);
      check_val({tag, "_nwr"}, wr_log.size(), exp_w.size());
      if (wr_log.size() == exp_w.size())
         for (int i = 0; i < exp_w.size(); i++)
            check_val($sformatf("%s_wr%0d", tag, i), 32'(wr_log[i]), 32'(exp_w[i]));
      check_val({tag, "_ndone"}, done_log.size(), 32'd1);
      $display("svc %s req=%b grant=%b period=0x%08h writes=%0d mode=%0d",
               tag, req_v, exp_g, p, wr_log.size(), mode);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   initial begin
      reset   = 1'b1;
      req     = '0;
      abort   = 1'b0;
      tmr_irq = 1'b0;
      period  = {32'h8000_FFFF, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0001_0032};
      do_reset();
      step();
      check_val("rst_grant", 32'(grant), 32'd0);
      check_val("rst_done", 32'(done), 32'd0);
      check_val("rst_aborted", 32'(aborted), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_cs", 32'(tmr_chipselect), 32'd0);
      check_val("rst_wrn", 32'(tmr_write_n), 32'd1);
      check_val("rst_addr", 32'(tmr_address), 32'd0);
      check_val("rst_data", 32'(tmr_writedata), 32'd0);

      // Single service, irq completion.
      service("basic", 4'b0001, 4'b0001, 0, 1'b0);
      req = '0;

      // Round-robin with all requesting, back-to-back, from a fresh pointer.
      do_reset();
      service("rr0", 4'b1111, 4'b0001, 0, 1'b0);
      service("rr1", 4'b1111, 4'b0010, 0, 1'b0);
      service("rr2", 4'b1111, 4'b0100, 0, 1'b0);   // period 0
      service("rr3", 4'b1111, 4'b1000, 0, 1'b0);   // full 32-bit period
      service("rr4", 4'b1111, 4'b0001, 0, 1'b0);
      req = '0;

      service("abort", 4'b0010, 4'b0010, 1, 1'b0);
      req = '0;
      service("both", 4'b0100, 4'b0100, 2, 1'b0);
      req = '0;
      service("drop", 4'b0100, 4'b0100, 0, 1'b1);   // wrap from pointer 3
      req = '0;
      service("rrskip", 4'b1001, 4'b1000, 0, 1'b0);
      req = '0;

      // Reset while waiting for the interrupt.
      req = 4'b0001;
      step(); step(); step(); step();              // WAIT_IRQ
      req = '0;
      check_val("mid_busy", 32'(busy), 32'd1);
      wr_log.delete();
      done_log.delete();
      reset   = 1'b1;
      tmr_irq = 1'b1;
      step();
      reset = 1'b0;
      check_val("mid_busy_rst", 32'(busy), 32'd0);
      check_val("mid_grant_rst", 32'(grant), 32'd0);
      check_val("mid_cs_rst", 32'(tmr_chipselect), 32'd0);
      step(); step(); step();
      tmr_irq = 1'b0;
      check_val("mid_nwr", wr_log.size(), 32'd0);
      check_val("mid_ndone", done_log.size(), 32'd0);
      $display("mid-operation reset: writes=%0d dones=%0d", wr_log.size(), done_log.size());
      service("post_rst", 4'b0011, 4'b0001, 0, 1'b0);
      req = '0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/unsaved_timer_sched.md
UNSAVED_TIMER_SCHED -- requirements
Module: unsaved_timer_sched

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 The block SHALL have parameter: NUM_REQ, 4, number of requesters (legal 2..8).
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: reset  input  1  synchronous active-high reset.
REQ-005 Port: req  input  NUM_REQ  per-requester timeout request level.
REQ-006 Port: period  input  32*NUM_REQ  packed periods; requester i uses bits [32i+31:32i].
REQ-007 Port: abort  input  1  cancels the timeout currently being waited on.
REQ-008 Port: grant  output  NUM_REQ  one-hot; identifies the requester being served.
REQ-009 Port: done  output  NUM_REQ  one-cycle completion pulse to the served requester.
REQ-010 Port: aborted  output  1  one-cycle pulse, coincident with done, when completion was by abort.
REQ-011 Port: busy  output  1  high in every state except IDLE.
REQ-012 Port: tmr_address  output  3  timer register select.
REQ-013 Port: tmr_chipselect  output  1  timer select.
REQ-014 Port: tmr_write_n  output  1  active-low timer write strobe.
REQ-015 Port: tmr_writedata  output  16  timer write data.
REQ-016 Port: tmr_irq  input  1  timer interrupt (level, held until status write).

Function
REQ-017 Timer map SHALL be: 0 status (any write clears timeout), 1 control (bit0 irq enable, bit1 continuous, bit2 start, bit3 stop), 2 period low, 3 period high; writes take effect in one cycle, no wait states.
REQ-018 FSM states SHALL be IDLE, WR_PL, WR_PH, WR_CTRL, WAIT_IRQ, STOP, CLR, DONE.
REQ-019 IDLE: if any req bit set, register one-hot grant and the granted 32-bit period, go WR_PL next cycle; else stay.
REQ-020 Arbitration SHALL be round-robin: search starts at (last granted index + 1) mod NUM_REQ; after reset the pointer SHALL favour index 0.
REQ-021 req SHALL be sampled only in IDLE; deasserting req after grant SHALL NOT cancel service.
REQ-022 WR_PL: one write, address 2, data period[15:0]; then WR_PH.
REQ-023 WR_PH: one write, address 3, data period[31:16]; then WR_CTRL.
REQ-024 WR_CTRL: one write, address 1, data 0x0005 (start, irq enable, one-shot); then WAIT_IRQ.
REQ-025 WAIT_IRQ: tmr_irq high -> CLR; else abort high -> STOP; else stay; no cycle limit.
REQ-026 tmr_irq and abort high in the same WAIT_IRQ cycle SHALL be treated as normal completion (aborted not pulsed).
REQ-027 abort outside WAIT_IRQ SHALL be ignored.
REQ-028 STOP: one write, address 1, data 0x0008 (stop, irq disabled); then CLR, with abort remembered.
REQ-029 CLR: one write, address 0, data 0x0000; then DONE.
REQ-030 DONE: done[granted] high one cycle, aborted high if via STOP; next state IDLE; grant SHALL clear entering IDLE.
REQ-031 Outside write states bus outputs SHALL be chipselect 0, write_n 1, address 0, writedata 0; in write states chipselect 1, write_n 0 for exactly one cycle.
REQ-032 Period 0 SHALL be passed unmodified; 32-bit period SHALL NOT be truncated or offset.
REQ-033 Back-to-back service: earliest next WR_PL SHALL be two cycles after DONE (IDLE cycle in between).

Reset
REQ-034 Reset SHALL force IDLE, grant 0, done 0, aborted 0, busy 0, idle bus values, RR pointer to favour index 0, abort flag 0.
REQ-035 Reset asserted mid-operation SHALL abandon the transaction without further timer writes; no done pulse.

Verification
REQ-036 req=0001, period0=0x0001_0032 -> writes (2,0x0032),(3,0x0001),(1,0x0005); after tmr_irq, write (0,0x0000); done=0001 one cycle; busy low after.
REQ-037 req=1111 held through four services -> grant order 0001,0010,0100,1000; then 0001 again.
REQ-038 In WAIT_IRQ assert abort -> writes (1,0x0008),(0,0x0000); done and aborted pulse together.
REQ-039 abort and tmr_irq same cycle -> no STOP write; done pulses, aborted stays 0.
REQ-040 Reset during WAIT_IRQ -> next cycle IDLE, grant 0, no bus writes, no done.
REQ-041 req=0100 dropped after grant -> full write sequence still issued, done=0100.
